vr_source: RTL and testbench
============================

Name: vr_source

Overview:
- Valid/ready traffic source that drives the transmit side of the mon_intf handshake toward a ready-driving receiver.
- Sends a programmed number of beats with deterministic payloads.
- Inserts pseudo-random idle gaps between beats, drawn from a free-running LFSR.
- Counts backpressure stall cycles so the bench and the monitor can cross-check them.

Parameters:
- DATA_W, 8: payload width.
- COUNT_W, 16: width of num_beats and of the beat counter.
- SEED, 16'hACE1: LFSR reset value; must be non-zero.
- GAP_EN, 1: 1 enables random inter-beat gaps; 0 makes the source send back-to-back.
- GAP_THRESH, 8'd64: a gap is inserted when lfsr[15:8] < GAP_THRESH, about 25% of draws.
- DATA_BASE, 'h10: payload of beat 0.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a transfer; honoured only in IDLE.
- num_beats  in  COUNT_W  beat count, sampled on an accepted start.
- valid  out  1  beat valid.
- data  out  DATA_W  beat payload.
- ready  in  1  receiver ready.
- busy  out  1  high in GAP or SEND.
- done  out  1  one-cycle pulse after the last beat is accepted.
- stall_cnt  out  16  count of cycles with valid && !ready in the current transfer.

Behaviour:
- Reset is synchronous: at a clk edge with rst_n=0, all outputs go to 0 (valid, data, busy, done, stall_cnt), state=IDLE, beat_idx=0, gap_cnt=0, lfsr=SEED.
- Reset mid-transfer: valid drops at that edge even with a handshake pending. The transfer is abandoned and is not resumed.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. Advances every cycle when not in reset.
- Gap draw: gap = (GAP_EN && lfsr[15:8] < GAP_THRESH) ? lfsr[2:0] : 0. A draw of 0 means no gap. The draw is taken from the current lfsr value at each point where a gap decision is made.
- Handshake: a beat transfers at a rising edge where valid && ready.
  - Once valid=1, valid and data stay constant until that transfer.
  - valid never drops without a handshake, except on reset.
- States are IDLE, GAP, SEND and DONE.
- IDLE:
  - On start, latch num_beats, clear stall_cnt and beat_idx.
  - If num_beats==0, go to DONE.
  - Otherwise draw a gap: gap>0 loads gap_cnt=gap and goes to GAP; gap=0 goes to SEND with valid=1 and data=DATA_BASE at the next cycle.
  - Latency from start to first valid is 1 cycle when the gap is 0.
- GAP:
  - valid=0; gap_cnt decrements each cycle.
  - When gap_cnt==1, go to SEND and drive data=DATA_BASE+beat_idx, truncated to DATA_W with wrap-around.
- SEND:
  - On a handshake, beat_idx++.
  - If this was the last beat (beat_idx==num_beats-1), set valid=0 and go to DONE.
  - Otherwise draw a gap. With gap=0, stay in SEND with valid held at 1 and data advanced in the same edge, so beats are back-to-back.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- start while busy or in DONE is ignored; the latched num_beats is unchanged.
- start and reset in the same cycle: reset wins.
- stall_cnt increments in each cycle with valid && !ready, saturates at 16'hFFFF, and holds after done until the next accepted start.
- Arithmetic: beat_idx and the num_beats comparison are COUNT_W wide and unsigned. Payload addition wraps modulo 2^DATA_W.

Decomposition:
- Package vr_pkg holds:
  - the state enum vr_state_e {IDLE, GAP, SEND, DONE};
  - the LFSR tap constant LFSR_TAPS = 16'hB400;
  - the gap-field width GAP_W = 3.
- One sub-module, vr_lfsr16 (parameter SEED; ports clk, rst_n, lfsr[15:0]), so the source reuses a generator distinct from the receiver's one.
- The FSM, counters and handshake logic stay in vr_source.

Test Plan:
1. GAP_EN=0, DATA_BASE=8'h10, num_beats=4, ready tied 1, start pulse at cycle 0 -> valid high in cycles 1–4, data 10,11,12,13, done pulse in cycle 5, stall_cnt=0.
2. GAP_EN=0, num_beats=2, ready=0 in cycles 1–3 then 1 -> data=10 held stable in cycles 1–4, beat 11 in cycle 5, stall_cnt=3, done in cycle 6.
3. num_beats=0 with start -> valid stays 0, done pulses in cycle 1, busy never asserts.
4. num_beats=3; start re-pulsed with num_beats=9 during beat 1 -> exactly 3 beats are sent and one done pulse occurs.
5. Reset asserted after 2 of 5 beats -> valid, busy and stall_cnt are 0 at that edge; a new start with num_beats=2 sends 10,11.
6. GAP_EN=1, num_beats=256, receiver drives random ready (about 20% low, up to 7 cycles) -> exactly 256 handshakes with data 10..FF,00..0F (wrap), no valid drop without a handshake, every idle gap ≤7 cycles, stall_cnt equals the bench's count of valid&&!ready cycles.

Source files
------------

// File: rtl/vr_pkg.sv
// Shared types and helpers for the valid/ready traffic source.
package vr_pkg;

  typedef enum logic [1:0] {IDLE, GAP, SEND, DONE} vr_state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          GAP_W     = 3;

  // One step of the right-shifting Galois LFSR, x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // Idle-gap length for one draw; zero means no gap.
  function automatic logic [GAP_W-1:0] gap_draw(
    input logic [7:0]       hi,
    input logic [GAP_W-1:0] lo,
    input logic             en,
    input logic [7:0]       thresh
  );
    return (en && (hi < thresh)) ? lo : '0;
  endfunction

endpackage

// File: rtl/vr_lfsr16.sv
// Free-running 16-bit Galois LFSR; private instance so the source's gap
// pattern is independent of the receiver's generator.
module vr_lfsr16 import vr_pkg::*; #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr <= SEED;
    else        lfsr <= lfsr_step(lfsr);
  end

endmodule

// File: rtl/vr_source.sv
// Valid/ready beat source: sends num_beats payloads DATA_BASE+i with optional
// pseudo-random idle gaps, and counts backpressure stall cycles.
module vr_source import vr_pkg::*; #(
  parameter int                DATA_W     = 8,
  parameter int                COUNT_W    = 16,
  parameter logic [15:0]       SEED       = 16'hACE1,
  parameter bit                GAP_EN     = 1'b1,
  parameter logic [7:0]        GAP_THRESH = 8'd64,
  parameter logic [DATA_W-1:0] DATA_BASE  = 'h10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_beats,
  output logic               valid,
  output logic [DATA_W-1:0]  data,
  input  logic               ready,
  output logic               busy,
  output logic               done,
  output logic [15:0]        stall_cnt
);

  localparam logic [COUNT_W-1:0] C_ONE = COUNT_W'(1);
  localparam logic [GAP_W-1:0]   G_ONE = GAP_W'(1);

  vr_state_e          state_q, state_d;
  logic [COUNT_W-1:0] beat_q, beat_d;
  logic [COUNT_W-1:0] num_q, num_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               valid_d;
  logic [DATA_W-1:0]  data_d;
  logic [15:0]        stall_d;
  logic [15:0]        lfsr;
  logic [GAP_W-1:0]   gap;
  logic               hs;
  logic               lfsr_unused;

  vr_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .lfsr  (lfsr)
  );

  assign lfsr_unused = ^lfsr[7:GAP_W];
  assign gap  = gap_draw(lfsr[15:8], lfsr[GAP_W-1:0], GAP_EN, GAP_THRESH);
  assign hs   = valid && ready;
  assign busy = (state_q == GAP) || (state_q == SEND);
  assign done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    num_d   = num_q;
    gap_d   = gap_q;
    valid_d = valid;
    data_d  = data;
    stall_d = stall_cnt;
    if (valid && !ready && (stall_cnt != 16'hFFFF)) stall_d = stall_cnt + 16'd1;
    case (state_q)
      IDLE: begin
        if (start) begin
          num_d   = num_beats;
          beat_d  = '0;
          stall_d = '0;
          if (num_beats == '0) begin
            state_d = DONE;
          end else if (gap != '0) begin
            gap_d   = gap;
            state_d = GAP;
          end else begin
            valid_d = 1'b1;
            data_d  = DATA_BASE;
            state_d = SEND;
          end
        end
      end
      GAP: begin
        gap_d = gap_q - G_ONE;
        if (gap_q == G_ONE) begin
          valid_d = 1'b1;
          data_d  = DATA_BASE + DATA_W'(beat_q);
          state_d = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          beat_d = beat_q + C_ONE;
          if (beat_q == num_q - C_ONE) begin
            valid_d = 1'b0;
            state_d = DONE;
          end else if (gap != '0) begin
            valid_d = 1'b0;
            gap_d   = gap;
            state_d = GAP;
          end else begin
            // Back-to-back: next payload presented on the same edge.
            data_d = DATA_BASE + DATA_W'(beat_q + C_ONE);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      num_q     <= '0;
      gap_q     <= '0;
      valid     <= 1'b0;
      data      <= '0;
      stall_cnt <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      num_q     <= num_d;
      gap_q     <= gap_d;
      valid     <= valid_d;
      data      <= data_d;
      stall_cnt <= stall_d;
    end
  end

endmodule

// File: tb/tb_vr_source.sv
// Directed bench for vr_source: dut0 has gaps disabled, dut1 has them enabled.
module tb_vr_source;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, ready = 1'b0;
  logic [15:0] num_beats = '0;
  logic        valid, busy, done;
  logic [7:0]  data;
  logic [15:0] stall_cnt;

  logic        g_start = 1'b0, g_ready = 1'b0;
  logic [15:0] g_num_beats = '0;
  logic        g_valid, g_busy, g_done;
  logic [7:0]  g_data;
  logic [15:0] g_stall_cnt;

  int total = 0, passed = 0;

  vr_source #(.DATA_W(8), .COUNT_W(16), .SEED(16'hACE1), .GAP_EN(1'b0),
              .GAP_THRESH(8'd64), .DATA_BASE(8'h10)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_beats(num_beats),
    .valid(valid), .data(data), .ready(ready), .busy(busy), .done(done),
    .stall_cnt(stall_cnt));

  vr_source #(.DATA_W(8), .COUNT_W(16), .SEED(16'hACE1), .GAP_EN(1'b1),
              .GAP_THRESH(8'd64), .DATA_BASE(8'h10)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(g_start), .num_beats(g_num_beats),
    .valid(g_valid), .data(g_data), .ready(g_ready), .busy(g_busy), .done(g_done),
    .stall_cnt(g_stall_cnt));

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({valid, data, busy, done, stall_cnt} !== 27'd0)
      $display("FAIL reset_dut0 got v=%b d=%h b=%b dn=%b s=%0d exp all 0", valid, data, busy, done, stall_cnt);
    else passed++;
    total++;
    if ({g_valid, g_data, g_busy, g_done, g_stall_cnt} !== 27'd0)
      $display("FAIL reset_dut1 got v=%b d=%h b=%b dn=%b s=%0d exp all 0", g_valid, g_data, g_busy, g_done, g_stall_cnt);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({valid, busy, done} !== 3'b000)
      $display("FAIL idle_after_reset got v=%b b=%b dn=%b exp 000", valid, busy, done);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d;
    @(negedge clk);
    ready = 1'b1; start = 1'b1; num_beats = 16'd4;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      total++;
      if (c <= 4) begin
        exp_d = 8'h10 + 8'(c - 1);
        if ({valid, data, busy, done} !== {1'b1, exp_d, 1'b1, 1'b0})
          $display("FAIL b2b_beat%0d got v=%b d=%h b=%b dn=%b exp v=1 d=%h b=1 dn=0", c, valid, data, busy, done, exp_d);
        else passed++;
      end else if (c == 5) begin
        if ({valid, busy, done, stall_cnt} !== {3'b001, 16'd0})
          $display("FAIL b2b_done got v=%b b=%b dn=%b s=%0d exp v=0 b=0 dn=1 s=0", valid, busy, done, stall_cnt);
        else passed++;
      end else begin
        if (done !== 1'b0) $display("FAIL b2b_done_pulse got dn=%b exp 0", done);
        else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    ready = 1'b0; start = 1'b1; num_beats = 16'd2;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      ready = (c >= 4);
      total++;
      if (c <= 4) begin
        if ({valid, data} !== {1'b1, 8'h10})
          $display("FAIL bp_hold%0d got v=%b d=%h exp v=1 d=10", c, valid, data);
        else passed++;
      end else if (c == 5) begin
        if ({valid, data} !== {1'b1, 8'h11})
          $display("FAIL bp_beat1 got v=%b d=%h exp v=1 d=11", valid, data);
        else passed++;
      end else begin
        if ({valid, done, stall_cnt} !== {2'b01, 16'd3})
          $display("FAIL bp_done got v=%b dn=%b s=%0d exp v=0 dn=1 s=3", valid, done, stall_cnt);
        else passed++;
      end
    end
  endtask

  task automatic test_zero_beats();
    @(negedge clk);
    ready = 1'b1; start = 1'b1; num_beats = 16'd0;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({valid, busy, done} !== 3'b001)
      $display("FAIL zero_done got v=%b b=%b dn=%b exp 001", valid, busy, done);
    else passed++;
    @(negedge clk);
    total++;
    if ({valid, busy, done} !== 3'b000)
      $display("FAIL zero_after got v=%b b=%b dn=%b exp 000", valid, busy, done);
    else passed++;
  endtask

  task automatic test_restart_ignored();
    int hs = 0, dn = 0;
    @(negedge clk);
    ready = 1'b1; start = 1'b1; num_beats = 16'd3;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = (c == 2);
      num_beats = (c == 2) ? 16'd9 : 16'd3;
      if (valid && ready) begin
        total++;
        if (data !== 8'h10 + 8'(hs))
          $display("FAIL restart_data%0d got %h exp %h", hs, data, 8'h10 + 8'(hs));
        else passed++;
        hs++;
      end
      if (done) dn++;
    end
    start = 1'b0;
    total++;
    if (hs !== 3) $display("FAIL restart_beats got %0d exp 3", hs);
    else passed++;
    total++;
    if (dn !== 1) $display("FAIL restart_done_pulses got %0d exp 1", dn);
    else passed++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ready = 1'b1; start = 1'b1; num_beats = 16'd5;
    @(negedge clk); start = 1'b0; ready = 1'b1;
    @(negedge clk); ready = 1'b0;
    @(negedge clk); ready = 1'b1;
    @(negedge clk); ready = 1'b1;
    total++;
    if ({valid, data, stall_cnt} !== {1'b1, 8'h12, 16'd1})
      $display("FAIL mid_pre_reset got v=%b d=%h s=%0d exp v=1 d=12 s=1", valid, data, stall_cnt);
    else passed++;
    rst_n = 1'b0; start = 1'b1; num_beats = 16'd7;
    @(negedge clk);
    total++;
    if ({valid, data, busy, done, stall_cnt} !== 27'd0)
      $display("FAIL mid_reset got v=%b d=%h b=%b dn=%b s=%0d exp all 0", valid, data, busy, done, stall_cnt);
    else passed++;
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    total++;
    if ({valid, busy} !== 2'b00)
      $display("FAIL mid_no_resume got v=%b b=%b exp 00", valid, busy);
    else passed++;
    start = 1'b1; num_beats = 16'd2;
    @(negedge clk); start = 1'b0;
    total++;
    if ({valid, data} !== {1'b1, 8'h10})
      $display("FAIL mid_new0 got v=%b d=%h exp v=1 d=10", valid, data);
    else passed++;
    @(negedge clk);
    total++;
    if ({valid, data} !== {1'b1, 8'h11})
      $display("FAIL mid_new1 got v=%b d=%h exp v=1 d=11", valid, data);
    else passed++;
    @(negedge clk);
    total++;
    if ({valid, done} !== 2'b01)
      $display("FAIL mid_new_done got v=%b dn=%b exp v=0 dn=1", valid, done);
    else passed++;
  endtask

  task automatic test_random_gaps();
    int hs = 0, stalls = 0, low_run = 0, idle_run = 0, max_idle = 0;
    int gaps = 0, viol = 0, dn = 0;
    logic pv = 1'b0, pr = 1'b0;
    logic [7:0] pd = '0;
    @(negedge clk);
    g_ready = 1'b1; g_start = 1'b1; g_num_beats = 16'd256;
    for (int cyc = 0; cyc < 5000 && dn == 0; cyc++) begin
      @(negedge clk);
      g_start = 1'b0;
      if (low_run > 0) begin
        g_ready = 1'b0; low_run--;
      end else if ($urandom_range(0, 99) < 6) begin
        g_ready = 1'b0; low_run = int'($urandom_range(0, 6));
      end else g_ready = 1'b1;
      if (pv && !pr && (!g_valid || g_data !== pd)) viol++;
      if (g_busy && !g_valid) idle_run++;
      else begin
        if (idle_run > 0) gaps++;
        if (idle_run > max_idle) max_idle = idle_run;
        idle_run = 0;
      end
      if (g_valid && g_ready) begin
        total++;
        if (g_data !== 8'h10 + 8'(hs))
          $display("FAIL rnd_data%0d got %h exp %h", hs, g_data, 8'h10 + 8'(hs));
        else passed++;
        hs++;
      end
      if (g_valid && !g_ready) stalls++;
      if (g_done) dn++;
      pv = g_valid; pr = g_ready; pd = g_data;
    end
    g_ready = 1'b0;
    total++;
    if (dn !== 1) $display("FAIL rnd_done got %0d pulses within budget exp 1", dn);
    else passed++;
    total++;
    if (hs !== 256) $display("FAIL rnd_beats got %0d exp 256", hs);
    else passed++;
    total++;
    if (viol !== 0) $display("FAIL rnd_hold got %0d violations exp 0", viol);
    else passed++;
    total++;
    if (max_idle > 7 || gaps == 0)
      $display("FAIL rnd_gaps got max=%0d count=%0d exp max<=7 count>0", max_idle, gaps);
    else passed++;
    total++;
    if (g_stall_cnt !== 16'(stalls))
      $display("FAIL rnd_stall got %0d exp %0d", g_stall_cnt, stalls);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_zero_beats();
    test_restart_ignored();
    test_reset_mid();
    test_random_gaps();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
